// File: rtl/audio_sample_sequencer.sv
// rtl/audio_sample_sequencer.sv - paced ROM fetch and per-period sample presentation for audio playback
module audio_sample_sequencer #(
  parameter int CLK_HZ      = 100000000,
  parameter int SAMPLE_RATE = 8000,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              playing,
  output logic              paused,
  output logic              done,
  output logic [31:0]       sample_index
);

  localparam int DIV = CLK_HZ / SAMPLE_RATE;
  localparam int TICK_W = $clog2(DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

  state_t                 state_q;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [ADDR_W-1:0]      cur_q, cur_d;
  logic [ADDR_W-1:0]      start_q, end_q, rom_addr_q;
  logic [ROM_LATENCY-1:0] fetch_q, fetch_d;
  logic [ROM_LATENCY-1:0] last_q, last_d;
  logic                   issue, issue_last, capture;
  logic [DATA_W-1:0]      sample_q;
  logic                   valid_q, done_q;
  logic [31:0]            index_q;

  // Sample-period pacing: the counter only runs in PLAY and its wrap cycle issues one fetch
  always_comb begin
    tick_d     = tick_q;
    cur_d      = cur_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    if (state_q == S_PLAY && !stop) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        issue  = 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
    if (issue) begin
      if (cur_q != end_q) begin
        cur_d = cur_q + 1'b1;
      end else if (loop_en) begin
        cur_d = start_q;
      end else begin
        issue_last = 1'b1;
      end
    end
  end

  // In-flight fetch tracker: one slot per cycle of ROM latency, tagged when it ends the pass
  always_comb begin
    fetch_d    = '0;
    last_d     = '0;
    fetch_d[0] = issue;
    last_d[0]  = issue_last;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      fetch_d[i] = fetch_q[i-1];
      last_d[i]  = last_q[i-1];
    end
  end

  assign capture = fetch_q[ROM_LATENCY-1];

  // Control FSM plus every registered output; stop and reset flush the fetch tracker
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      cur_q      <= '0;
      start_q    <= '0;
      end_q      <= '0;
      rom_addr_q <= '0;
      fetch_q    <= '0;
      last_q     <= '0;
      sample_q   <= MIDSCALE;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      index_q    <= '0;
    end else begin
      tick_q  <= tick_d;
      cur_q   <= cur_d;
      fetch_q <= fetch_d;
      last_q  <= last_d;
      valid_q <= capture;
      done_q  <= capture & last_q[ROM_LATENCY-1];
      if (issue) begin
        rom_addr_q <= cur_q;
      end
      if (capture) begin
        sample_q <= rom_data;
        index_q  <= index_q + 32'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (play && !stop && end_addr >= start_addr) begin
            state_q <= S_PLAY;
            start_q <= start_addr;
            end_q   <= end_addr;
            cur_q   <= start_addr;
            tick_q  <= '0;
            index_q <= '0;
          end
        end
        default: begin
          if (stop) begin
            state_q  <= S_IDLE;
            sample_q <= MIDSCALE;
            index_q  <= index_q;
            fetch_q  <= '0;
            last_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
          end else if (done_q) begin
            state_q <= S_IDLE;
          end else if (play) begin
            state_q <= S_PLAY;
          end else if (pause) begin
            state_q <= S_PAUSE;
          end
        end
      endcase
    end
  end

  assign rom_addr     = rom_addr_q;
  assign rom_en       = fetch_q[0];
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign done         = done_q;
  assign sample_index = index_q;
  assign playing      = (state_q == S_PLAY);
  assign paused       = (state_q == S_PAUSE);

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// tb/tb_audio_sample_sequencer.sv - scoreboard bench for audio_sample_sequencer at ROM latency 1 and 3
module tb_audio_sample_sequencer;

  localparam int DIV     = 10;
  localparam int QD      = 1024;
  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam logic [7:0] MID = 8'h80;

  typedef struct {
    int          cyc;
    logic [7:0]  val;
    int unsigned idx;
    bit          last;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset, play, pause, stop, loop_en;
  logic [16:0] start_addr, end_addr;
  logic [16:0] rom_addr_w [2];
  logic        rom_en_w   [2];
  logic [7:0]  rom_data_w [2];
  logic [7:0]  sample_w   [2];
  logic        valid_w    [2];
  logic        playing_w  [2];
  logic        paused_w   [2];
  logic        done_w     [2];
  logic [31:0] index_w    [2];
  logic [16:0] a1, a2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int          m_mode   [2] = '{default: 0};
  logic [7:0]  m_sample [2] = '{default: 8'h80};
  int unsigned m_index  [2] = '{default: 0};
  int          m_addr   [2] = '{default: 0};
  int          m_next   [2] = '{default: 0};
  int          m_start  [2] = '{default: 0};
  int          m_end    [2] = '{default: 0};
  int          m_played [2] = '{default: 0};
  bit          m_ending [2] = '{default: 0};
  bit          inf_v    [2] = '{default: 0};
  int          inf_due  [2] = '{default: 0};
  int          inf_addr [2] = '{default: 0};
  bit          inf_last [2] = '{default: 0};

  ev_t vq [2][QD];
  int  vh [2] = '{default: 0};
  int  vt [2] = '{default: 0};
  int  rq_cyc  [2][QD];
  int  rq_addr [2][QD];
  int  rh [2] = '{default: 0};
  int  rt [2] = '{default: 0};

  always #5 clk = ~clk;

  audio_sample_sequencer #(
    .CLK_HZ(100), .SAMPLE_RATE(10), .ADDR_W(17), .DATA_W(8), .ROM_LATENCY(1)
  ) dut_l1 (
    .clk(clk), .reset(reset), .play(play), .pause(pause), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr),
    .rom_addr(rom_addr_w[0]), .rom_en(rom_en_w[0]), .rom_data(rom_data_w[0]),
    .sample(sample_w[0]), .sample_valid(valid_w[0]), .playing(playing_w[0]),
    .paused(paused_w[0]), .done(done_w[0]), .sample_index(index_w[0])
  );

  audio_sample_sequencer #(
    .CLK_HZ(100), .SAMPLE_RATE(10), .ADDR_W(17), .DATA_W(8), .ROM_LATENCY(3)
  ) dut_l3 (
    .clk(clk), .reset(reset), .play(play), .pause(pause), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr),
    .rom_addr(rom_addr_w[1]), .rom_en(rom_en_w[1]), .rom_data(rom_data_w[1]),
    .sample(sample_w[1]), .sample_valid(valid_w[1]), .playing(playing_w[1]),
    .paused(paused_w[1]), .done(done_w[1]), .sample_index(index_w[1])
  );

  // ROM contents are ROM[a] = a (low byte); latency 1 reads combinationally, latency 3 through two stages
  assign rom_data_w[0] = rom_addr_w[0][7:0];
  always @(posedge clk) begin
    a1 <= rom_addr_w[1];
    a2 <= a1;
  end
  assign rom_data_w[1] = a2[7:0];

  function automatic logic [7:0] rom_val(input int a);
    return 8'(a);
  endfunction

  task automatic chk(input bit ok, input string msg);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endtask

  task automatic push_v(input int k, input int c, input logic [7:0] v, input int unsigned idx, input bit last);
    vq[k][vt[k] % QD].cyc  = c;
    vq[k][vt[k] % QD].val  = v;
    vq[k][vt[k] % QD].idx  = idx;
    vq[k][vt[k] % QD].last = last;
    vt[k]++;
  endtask

  task automatic push_r(input int k, input int c, input int a);
    rq_cyc[k][rt[k] % QD]  = c;
    rq_addr[k][rt[k] % QD] = a;
    rt[k]++;
  endtask

  // Reference behaviour: one fetch every DIV cycles spent playing, data appears lat cycles after the fetch
  task automatic model_step(input int k, input int lat);
    bit was_end;
    if (reset) begin
      m_mode[k] = M_IDLE; m_sample[k] = MID; m_index[k] = 0; m_addr[k] = 0;
      m_next[k] = 0; m_start[k] = 0; m_end[k] = 0; m_played[k] = 0;
      m_ending[k] = 0; inf_v[k] = 0;
      return;
    end
    was_end = m_ending[k];
    m_ending[k] = 0;
    if (stop && m_mode[k] != M_IDLE) begin
      m_mode[k] = M_IDLE;
      m_sample[k] = MID;
      inf_v[k] = 0;
      return;
    end
    if (inf_v[k] && inf_due[k] == cyc) begin
      inf_v[k] = 0;
      m_sample[k] = rom_val(inf_addr[k]);
      m_index[k]++;
      push_v(k, cyc, m_sample[k], m_index[k], inf_last[k]);
      m_ending[k] = inf_last[k];
    end
    if (m_mode[k] == M_PLAY) begin
      m_played[k]++;
      if (m_played[k] % DIV == 0) begin
        push_r(k, cyc, m_next[k]);
        m_addr[k] = m_next[k];
        inf_v[k] = 1; inf_due[k] = cyc + lat; inf_addr[k] = m_next[k];
        inf_last[k] = (m_next[k] == m_end[k]) && !loop_en;
        if (m_next[k] != m_end[k]) m_next[k]++;
        else if (loop_en) m_next[k] = m_start[k];
      end
    end
    if (was_end) begin
      m_mode[k] = M_IDLE;
    end else if (m_mode[k] == M_IDLE) begin
      if (play && !stop && end_addr >= start_addr) begin
        m_mode[k] = M_PLAY; m_played[k] = 0; m_index[k] = 0;
        m_start[k] = int'(start_addr); m_end[k] = int'(end_addr); m_next[k] = int'(start_addr);
      end
    end else if (play) begin
      m_mode[k] = M_PLAY;
    end else if (pause) begin
      m_mode[k] = M_PAUSE;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step(0, 1);
    model_step(1, 3);
  end

  // Monitor: status every cycle, and every valid/rom_en pulse popped against the expected queues
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(playing_w[k] == (m_mode[k] == M_PLAY) && paused_w[k] == (m_mode[k] == M_PAUSE) &&
          sample_w[k] == m_sample[k] && index_w[k] == m_index[k] && rom_addr_w[k] == 17'(m_addr[k]),
          $sformatf("status k=%0d cyc=%0d got play=%0b pause=%0b sample=%0h idx=%0d addr=%0d want %0b %0b %0h %0d %0d",
                    k, cyc, playing_w[k], paused_w[k], sample_w[k], index_w[k], rom_addr_w[k],
                    m_mode[k] == M_PLAY, m_mode[k] == M_PAUSE, m_sample[k], m_index[k], m_addr[k]));
      while (vh[k] != vt[k] && vq[k][vh[k] % QD].cyc < cyc) begin
        chk(1'b0, $sformatf("missed_valid k=%0d got none want valid at cyc %0d", k, vq[k][vh[k] % QD].cyc));
        vh[k]++;
      end
      while (rh[k] != rt[k] && rq_cyc[k][rh[k] % QD] < cyc) begin
        chk(1'b0, $sformatf("missed_rom_en k=%0d got none want rom_en at cyc %0d", k, rq_cyc[k][rh[k] % QD]));
        rh[k]++;
      end
      if (valid_w[k]) begin
        if (vh[k] == vt[k]) begin
          chk(1'b0, $sformatf("unexpected_valid k=%0d cyc=%0d got valid want none", k, cyc));
        end else begin
          ev_t e;
          e = vq[k][vh[k] % QD];
          vh[k]++;
          chk(e.cyc == cyc && sample_w[k] == e.val && index_w[k] == e.idx && done_w[k] == e.last,
              $sformatf("valid k=%0d cyc=%0d got sample=%0h idx=%0d done=%0b want cyc=%0d sample=%0h idx=%0d done=%0b",
                        k, cyc, sample_w[k], index_w[k], done_w[k], e.cyc, e.val, e.idx, e.last));
        end
      end else if (done_w[k]) begin
        chk(1'b0, $sformatf("done_alone k=%0d cyc=%0d got done=1 want 0", k, cyc));
      end
      if (rom_en_w[k]) begin
        if (rh[k] == rt[k]) begin
          chk(1'b0, $sformatf("unexpected_rom_en k=%0d cyc=%0d got rom_en want none", k, cyc));
        end else begin
          chk(rq_cyc[k][rh[k] % QD] == cyc && rom_addr_w[k] == 17'(rq_addr[k][rh[k] % QD]),
              $sformatf("rom_en k=%0d cyc=%0d got addr=%0d want cyc=%0d addr=%0d",
                        k, cyc, rom_addr_w[k], rq_cyc[k][rh[k] % QD], rq_addr[k][rh[k] % QD]));
          rh[k]++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd(input bit p, input bit pa, input bit s);
    play = p; pause = pa; stop = s;
    @(negedge clk);
    play = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  task automatic window(input int s, input int e, input bit lp);
    start_addr = 17'(s); end_addr = 17'(e); loop_en = lp;
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
    start_addr = '0; end_addr = '0;
    idle(3);
    reset = 1'b0;
    idle(2);
    window(4, 6, 0); cmd(1, 0, 0); idle(40);
    window(4, 5, 1); cmd(1, 0, 0); idle(45); loop_en = 1'b0; idle(30);
    window(4, 6, 0); cmd(1, 0, 0); idle(14); cmd(0, 1, 0); idle(24); cmd(1, 0, 0); idle(50);
    window(2, 9, 0); cmd(1, 0, 0);
    for (int i = 0; i < 30 && !rom_en_w[0]; i++) @(negedge clk);
    chk(rom_en_w[0] == 1'b1, $sformatf("wait_rom_en got rom_en=%0b want 1 within 30 cycles", rom_en_w[0]));
    cmd(0, 0, 1); idle(10);
    window(3, 8, 0); cmd(1, 0, 0); idle(12); cmd(1, 0, 1); idle(5);
    window(9, 3, 0); cmd(1, 0, 0); idle(15);
    window(7, 7, 1); cmd(1, 0, 0); idle(35); cmd(0, 0, 1); loop_en = 1'b0; idle(3);
    window(1, 3, 0); cmd(1, 0, 0); idle(12); cmd(0, 1, 0); idle(5); cmd(0, 1, 0); idle(3);
    cmd(0, 0, 1); idle(3); cmd(0, 1, 0); idle(3);
    window(0, 15, 0); cmd(1, 0, 0); idle(25); reset = 1'b1; idle(1); reset = 1'b0; idle(5);
    for (int i = 0; i < 4000; i++) begin
      play  = ($urandom_range(0, 24) == 0);
      pause = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      reset = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 9) == 0) begin
        start_addr = 17'($urandom_range(0, 20));
        end_addr   = 17'($urandom_range(0, 24));
      end
      @(negedge clk);
    end
    play = 1'b0; pause = 1'b0; stop = 1'b0; reset = 1'b0; loop_en = 1'b0;
    idle(40);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(vh[k] == vt[k] && rh[k] == rt[k],
          $sformatf("drain k=%0d got pending valid=%0d rom_en=%0d want 0 0", k, vt[k] - vh[k], rt[k] - rh[k]));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
